// File: rtl/avmm_block_mover_if.sv
// rtl/avmm_block_mover_if.sv - Command, stream and Avalon-MM signal bundle for avmm_block_mover
//
// Purpose: carries every non-clock/reset signal of the block mover.
//   master modport: the block mover itself (Avalon-MM initiator side).
//   slave modport : the surrounding system (command source, streams, RAM).
// Signal summary:
//   cmd_start/cmd_write/cmd_addr/cmd_len : transfer command, sampled on cmd_start
//   busy/done                             : transfer status
//   in_data/in_valid/in_ready             : write stream (stream -> memory)
//   out_data/out_valid/out_ready          : read stream (memory -> stream)
//   avm_*                                 : Avalon-MM initiator towards the RAM slave
interface avmm_block_mover_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
);
  logic                  cmd_start;
  logic                  cmd_write;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [LEN_W-1:0]      cmd_len;
  logic                  busy;
  logic                  done;
  logic [DATA_W-1:0]     in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_W-1:0]     avm_address;
  logic [DATA_W/8-1:0]   avm_byteenable;
  logic                  avm_chipselect;
  logic                  avm_clken;
  logic                  avm_read;
  logic                  avm_write;
  logic [DATA_W-1:0]     avm_writedata;
  logic [DATA_W-1:0]     avm_readdata;
  logic                  avm_waitrequest;

  modport master (
    input  cmd_start, cmd_write, cmd_addr, cmd_len,
    input  in_data, in_valid, out_ready,
    input  avm_readdata, avm_waitrequest,
    output busy, done, in_ready, out_data, out_valid,
    output avm_address, avm_byteenable, avm_chipselect, avm_clken,
    output avm_read, avm_write, avm_writedata
  );

  modport slave (
    output cmd_start, cmd_write, cmd_addr, cmd_len,
    output in_data, in_valid, out_ready,
    output avm_readdata, avm_waitrequest,
    input  busy, done, in_ready, out_data, out_valid,
    input  avm_address, avm_byteenable, avm_chipselect, avm_clken,
    input  avm_read, avm_write, avm_writedata
  );
endinterface

// File: rtl/avmm_block_mover.sv
// rtl/avmm_block_mover.sv - Avalon-MM block mover between a stream port and word memory
//
// Purpose: moves cmd_len consecutive words (address wraps modulo 2^ADDR_W).
//   WRITE (cmd_write=1): in stream -> avm_write bursts of single words.
//   READ  (cmd_write=0): avm_read -> READ_LATENCY valid pipe -> FIFO -> out stream.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset; aborts any transfer without done
//   bus     : avmm_block_mover_if.master (command, status, streams, Avalon-MM)
// FIFO_DEPTH must be a power of two and at least READ_LATENCY+1.
module avmm_block_mover #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 11,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  avmm_block_mover_if.master bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RD_DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [LEN_W-1:0]        rem_q, rem_d;     // words not yet accepted by the slave
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    write_q, write_d;
  logic                    read_q, read_d;
  logic                    done_q, done_d;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;   // one bit per read in flight
  logic [DATA_W-1:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wp_q, rp_q;
  logic [PTR_W:0]          cnt_q, cnt_d;

  logic wr_acc, rd_acc, in_ready_c, in_hs, push, pop, credit_ok;
  int   outstanding;

  assign wr_acc = write_q & ~bus.avm_waitrequest;
  assign rd_acc = read_q & ~bus.avm_waitrequest;

  // A word sitting in avm_writedata is already taken from the stream, so it
  // is subtracted from the remaining count before asking for another one.
  assign in_ready_c = (state_q == S_WR) && (rem_q > LEN_W'(write_q)) &&
                      (!write_q || !bus.avm_waitrequest);
  assign in_hs      = bus.in_valid & in_ready_c;

  assign push = pipe_q[READ_LATENCY-1];
  assign pop  = (cnt_q != '0) & bus.out_ready;

  generate
    if (READ_LATENCY == 1) begin : g_pipe1
      assign pipe_d = rd_acc;
    end else begin : g_pipen
      assign pipe_d = {pipe_q[READ_LATENCY-2:0], rd_acc};
    end
  endgenerate

  always_comb begin
    outstanding = 0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      outstanding += int'(pipe_q[i]);
    end
  end

  // Every word buffered, in flight or requested holds a FIFO slot in reserve,
  // so a push can never find the FIFO full.
  assign credit_ok = (int'(cnt_q) + outstanding + int'(read_q)) < FIFO_DEPTH;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    wdata_d = wdata_q;
    write_d = write_q;
    read_d  = read_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_start) begin
          if (bus.cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = bus.cmd_addr;
            rem_d   = bus.cmd_len;
            state_d = bus.cmd_write ? S_WR : S_RD;
          end
        end
      end
      S_WR: begin
        if (wr_acc) begin
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - LEN_W'(1);
          write_d = 1'b0;
          if (rem_q == LEN_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        // Cannot coincide with the last acceptance: in_ready is low then.
        if (in_hs) begin
          wdata_d = bus.in_data;
          write_d = 1'b1;
        end
      end
      S_RD: begin
        if (rd_acc) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_RD_DRAIN;
          end
        end
        // A stalled request stays up; otherwise re-decide each cycle.
        if (!read_q || rd_acc) begin
          read_d = (rem_d != '0) && credit_ok;
        end
      end
      S_RD_DRAIN: begin
        read_d = 1'b0;
        if ((pipe_q == '0) && (cnt_q == '0)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
      done_q  <= 1'b0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      read_q  <= read_d;
      done_q  <= done_d;
      pipe_q  <= pipe_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem_q[wp_q] <= bus.avm_readdata;
        wp_q             <= wp_q + PTR_W'(1);
      end
      if (pop) begin
        rp_q <= rp_q + PTR_W'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  assign bus.busy           = (state_q != S_IDLE);
  assign bus.done           = done_q;
  assign bus.in_ready       = in_ready_c;
  assign bus.out_data       = fifo_mem_q[rp_q];
  assign bus.out_valid      = (cnt_q != '0);
  assign bus.avm_address    = addr_q;
  assign bus.avm_byteenable = '1;
  assign bus.avm_chipselect = read_q | write_q;
  assign bus.avm_clken      = 1'b1;
  assign bus.avm_read       = read_q;
  assign bus.avm_write      = write_q;
  assign bus.avm_writedata  = wdata_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && (cnt_q == FULL_CNT) && !pop));
  a_rd_wr_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(read_q && write_q));
endmodule

// File: tb/tb_avmm_block_mover.sv
// tb/tb_avmm_block_mover.sv - Self-checking bench for avmm_block_mover
module tb_avmm_block_mover;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 11;
  localparam int DEPTH  = 4;
  localparam int MEM_WORDS = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  avmm_block_mover_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  avmm_block_mover #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
    .READ_LATENCY(1), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.master)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] ram     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] in_q[$];
  logic [31:0] exp_wdata[$];
  int          exp_waddr[$];
  int          wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          wr_cyc_log[$];
  logic [31:0] out_log[$];

  int cyc = 0, done_cnt = 0, done_cyc = 0, last_pop_cyc = 0;
  int wr_total = 0, rd_total = 0, inflight = 0, max_inflight = 0, rw_both = 0;
  bit in_hs = 1'b0, rd_acc_f = 1'b0;
  logic [31:0] rd_word = '0;

  // Slave RAM and bus observer, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    in_hs    = bus.in_valid && bus.in_ready;
    rd_acc_f = bus.avm_read && !bus.avm_waitrequest;
    if (rd_acc_f) begin
      rd_word = ram[bus.avm_address];
      rd_total++;
      inflight++;
    end
    if (bus.avm_write && !bus.avm_waitrequest) begin
      ram[bus.avm_address] = bus.avm_writedata;
      wr_addr_log.push_back(int'(bus.avm_address));
      wr_data_log.push_back(bus.avm_writedata);
      wr_cyc_log.push_back(cyc);
      wr_total++;
    end
    if (bus.out_valid && bus.out_ready) begin
      out_log.push_back(bus.out_data);
      last_pop_cyc = cyc;
      inflight--;
    end
    if (inflight > max_inflight) max_inflight = inflight;
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.avm_read && bus.avm_write) rw_both++;
  end

  // Write-stream source and read-data return (latency 1).
  always @(posedge clk) begin
    #2;
    if (in_hs && in_q.size() > 0) void'(in_q.pop_front());
    in_hs = 1'b0;
    bus.in_valid = (in_q.size() != 0);
    if (in_q.size() != 0) bus.in_data = in_q[0];
    else bus.in_data = '0;
    if (rd_acc_f) bus.avm_readdata = rd_word;
    rd_acc_f = 1'b0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_cmd(input bit w, input int addr, input int len);
    bus.cmd_start = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = ADDR_W'(addr);
    bus.cmd_len   = LEN_W'(len);
    tick();
    bus.cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit rnd_ready);
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (rnd_ready) bus.out_ready = 1'b1;
    check({tag, "_done_seen"}, (done_cnt != d0), 1);
  endtask

  // Reference: the words a WRITE should store and where, modulo memory size.
  task automatic prepare_write(input int base, input int len);
    logic [31:0] w;
    int a;
    exp_wdata.delete(); exp_waddr.delete();
    wr_addr_log.delete(); wr_data_log.delete(); wr_cyc_log.delete();
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      a = (base + i) % MEM_WORDS;
      exp_wdata.push_back(w);
      exp_waddr.push_back(a);
      in_q.push_back(w);
      ref_mem[a] = w;
    end
  endtask

  task automatic check_write(input string tag, input bit consec);
    check({tag, "_nwr"}, wr_addr_log.size(), exp_waddr.size());
    for (int i = 0; i < exp_waddr.size() && i < wr_addr_log.size(); i++) begin
      check({tag, "_addr"}, wr_addr_log[i], exp_waddr[i]);
      check({tag, "_data"}, wr_data_log[i], exp_wdata[i]);
      if (consec && i > 0) check({tag, "_cyc"}, wr_cyc_log[i] - wr_cyc_log[i-1], 1);
    end
  endtask

  task automatic check_read(input string tag, input int base, input int len);
    check({tag, "_nrd"}, out_log.size(), len);
    for (int i = 0; i < len && i < out_log.size(); i++) begin
      check({tag, "_word"}, out_log[i], ref_mem[(base + i) % MEM_WORDS]);
    end
  endtask

  initial begin
    int d0, wr0, rd0, base, len, n;
    bus.cmd_start = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.out_ready = 1'b0; bus.avm_waitrequest = 1'b0; bus.avm_readdata = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    reset_n = 1'b0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end

    // Reset state
    repeat (3) tick();
    #1;
    check("rst_ctl", {bus.busy, bus.done, bus.in_ready, bus.out_valid,
                      bus.avm_read, bus.avm_write, bus.avm_chipselect}, 7'b0);
    check("rst_addr", bus.avm_address, 0);
    check("rst_wdata", bus.avm_writedata, 0);
    check("rst_be_clken", {bus.avm_byteenable, bus.avm_clken}, 5'b11111);
    reset_n = 1'b1;
    tick();
    check("idle_busy", bus.busy, 0);

    // WRITE with wraparound, no stalls
    prepare_write(10'h3FE, 4);
    tick();
    d0 = done_cnt;
    start_cmd(1'b1, 10'h3FE, 4);
    check("wrap_wr_busy", bus.busy, 1);
    wait_done("wrap_wr", 50, 1'b0);
    tick(); tick();
    check_write("wrap_wr", 1'b1);
    check("wrap_wr_done_once", done_cnt - d0, 1);
    check("wrap_wr_done_lat", done_cyc - wr_cyc_log[wr_cyc_log.size()-1], 1);
    check("wrap_wr_busy_end", bus.busy, 0);

    // READ back the same wrapped block
    bus.out_ready = 1'b1;
    out_log.delete();
    d0 = done_cnt;
    start_cmd(1'b0, 10'h3FE, 4);
    wait_done("wrap_rd", 60, 1'b0);
    tick(); tick();
    check_read("wrap_rd", 10'h3FE, 4);
    check("wrap_rd_done_once", done_cnt - d0, 1);
    check("wrap_rd_done_after_pop", done_cyc > last_pop_cyc, 1);

    // Length zero
    wr0 = wr_total; rd0 = rd_total; d0 = done_cnt;
    start_cmd(1'b1, int'($urandom_range(0, MEM_WORDS-1)), 0);
    check("len0_done_next", {bus.done, bus.busy}, 2'b10);
    tick();
    check("len0_done_pulse", {bus.done, bus.busy}, 2'b00);
    start_cmd(1'b0, 5, 0);
    repeat (4) tick();
    check("len0_no_bus", {wr_total - wr0, rd_total - rd0}, 0);
    check("len0_done_cnt", done_cnt - d0, 2);

    // Waitrequest stall on the 2nd write of len 3
    base = int'($urandom_range(0, MEM_WORDS-1));
    prepare_write(base, 3);
    tick();
    start_cmd(1'b1, base, 3);
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      bus.avm_waitrequest = 1'b1;
      #1;
      check("stall_addr", bus.avm_address, (base + 1) % MEM_WORDS);
      check("stall_wdata", bus.avm_writedata, exp_wdata[1]);
      check("stall_ctl", {bus.avm_write, bus.in_ready}, 2'b10);
      tick();
    end
    bus.avm_waitrequest = 1'b0;
    wait_done("stall", 50, 1'b0);
    check_write("stall", 1'b0);

    // Backpressure: reads must stop at FIFO_DEPTH words in hand
    base = int'($urandom_range(0, MEM_WORDS-1));
    bus.out_ready = 1'b0;
    out_log.delete();
    inflight = 0; max_inflight = 0;
    rd0 = rd_total; d0 = done_cnt;
    start_cmd(1'b0, base, 8);
    repeat (20) tick();
    check("bp_reads_issued", rd_total - rd0, DEPTH);
    check("bp_state", {bus.busy, bus.out_valid}, 2'b11);
    check("bp_no_done", done_cnt - d0, 0);
    bus.out_ready = 1'b1;
    wait_done("bp", 100, 1'b0);
    check_read("bp", base, 8);
    check("bp_max_inflight", max_inflight <= DEPTH, 1);

    // Reset in the middle of a READ len 16
    base = int'($urandom_range(0, MEM_WORDS-1));
    out_log.delete();
    start_cmd(1'b0, base, 16);
    n = 0;
    while (out_log.size() < 5 && n < 100) begin tick(); n++; end
    check("mid_rst_progress", out_log.size() >= 5, 1);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ctl", {bus.busy, bus.done, bus.in_ready, bus.out_valid,
                          bus.avm_read, bus.avm_write, bus.avm_chipselect}, 7'b0);
    check("mid_rst_data", {bus.avm_address, bus.avm_writedata, bus.out_data}, 0);
    repeat (3) tick();
    check("mid_rst_no_done", done_cnt - d0, 0);
    inflight = 0;
    reset_n = 1'b1;
    tick();
    base = int'($urandom_range(0, MEM_WORDS-1));
    out_log.delete();
    start_cmd(1'b0, base, 2);
    wait_done("post_rst", 50, 1'b0);
    check_read("post_rst", base, 2);

    // Start while busy is ignored
    base = int'($urandom_range(0, MEM_WORDS-1));
    prepare_write(base, 6);
    tick();
    d0 = done_cnt;
    start_cmd(1'b1, base, 6);
    tick();
    start_cmd(1'b0, (base + 100) % MEM_WORDS, 3);
    wait_done("busy_start", 60, 1'b0);
    repeat (4) tick();
    check_write("busy_start", 1'b1);
    check("busy_start_done_once", done_cnt - d0, 1);
    out_log.delete();
    start_cmd(1'b0, base, 6);
    wait_done("busy_start_rb", 60, 1'b0);
    check_read("busy_start_rb", base, 6);

    // Random write/readback with random out_ready
    for (int it = 0; it < 3; it++) begin
      base = int'($urandom_range(0, MEM_WORDS-1));
      len  = int'($urandom_range(1, 12));
      prepare_write(base, len);
      tick();
      start_cmd(1'b1, base, len);
      wait_done("rnd_wr", 100, 1'b0);
      check_write("rnd_wr", 1'b1);
      out_log.delete();
      inflight = 0; max_inflight = 0;
      start_cmd(1'b0, base, len);
      wait_done("rnd_rd", 300, 1'b1);
      check_read("rnd_rd", base, len);
      check("rnd_max_inflight", max_inflight <= DEPTH, 1);
    end

    check("rw_exclusive", rw_both, 0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
